// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial add/subtract datapath.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/fas_cell.sv
// One-bit full adder / full subtractor selected by mode; purely combinational.
module fas_cell
    import serial_arith_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic c,
    input  logic mode,
    output logic s,
    output logic co
);

    always_comb begin
        s = x ^ y ^ c;
        // In subtract mode c/co are borrow-in/borrow-out of x - y - c.
        if (mode == MODE_SUB) begin
            co = (~x & y) | (~(x ^ y) & c);
        end else begin
            co = (x & y) | (x & c) | (y & c);
        end
    end

endmodule

// File: rtl/serial_add_sub.sv
// LSB-first bit-serial adder/subtractor: one bit per clock through a single
// shared cell, carry/borrow kept in a flop, start/busy/done handshake.
module serial_add_sub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             mode_r;
    logic             cell_s;
    logic             cell_co;
    logic             accept;

    fas_cell u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .c    (carry),
        .mode (mode_r),
        .s    (cell_s),
        .co   (cell_co)
    );

    // A new operation is only taken when not mid-computation; DONE accepts
    // too so back-to-back operations lose no extra cycle.
    assign accept = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            mode_r <= MODE_ADD;
            result <= '0;
            cout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (accept) begin
            state  <= RUN;
            a_sh   <= a;
            b_sh   <= b;
            mode_r <= mode;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= {cell_s, r_sh[WIDTH-1:1]};
                    carry <= cell_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        result <= {cell_s, r_sh[WIDTH-1:1]};
                        cout   <= cell_co;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
